// File: rtl/tcore_uart_tx.sv
// UART transmitter with integrated TX FIFO. Configuration is latched at frame start,
// and tx_o is registered from next-state values so that it stays aligned with busy_o.
module tcore_uart_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    input  logic                          tx_en_i,
    input  logic                          wr_valid_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    output logic                          wr_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          fifo_empty_o,
    output logic                          fifo_full_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  baud_q, baud_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        par_q, par_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              tx_q, tx_d;

    logic              bit_end;
    logic              can_start;
    logic              par_en;

    // FIFO status and handshake
    assign fifo_count_o = count_q;
    assign fifo_empty_o = (count_q == '0);
    assign fifo_full_o  = (count_q == CW'(FIFO_DEPTH));
    assign wr_ready_o   = !fifo_full_o && rst_ni;
    assign push         = wr_valid_i && wr_ready_o;
    assign head         = mem_q[rptr_q];

    assign tx_o   = tx_q;
    assign busy_o = (state_q != S_IDLE);

    assign bit_end   = (baud_q == '0);
    assign can_start = tx_en_i && !fifo_empty_o;
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        div_d      = div_q;
        par_d      = par_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        pop        = 1'b0;

        // Every bit period reloads from the latched divisor when it expires.
        if (state_q != S_IDLE) begin
            baud_d = bit_end ? div_q : baud_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (can_start) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BW'(DATA_W - 1)) begin
                        state_d    = par_en ? S_PARITY : S_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (can_start) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            state_d    = S_START;
            shift_d    = head;
            div_d      = cfg_div_i;
            baud_d     = cfg_div_i;
            par_d      = cfg_parity_i;
            stop2_d    = cfg_stop2_i;
            stop_cnt_d = 1'b0;
            par_bit_d  = (^head) ^ (cfg_parity_i == 2'b10);
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            div_q      <= '0;
            par_q      <= '0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            div_q      <= div_d;
            par_q      <= par_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_tcore_uart_tx.sv
// Scoreboard bench for tcore_uart_tx: stimulus queues expected frames, a monitor checks the serial line.
module tb_tcore_uart_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_par;
    logic        cfg_stop2;
    logic        tx_en;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        tx;
    logic        busy;
    logic [4:0]  count;
    logic        empty;
    logic        full;

    logic [7:0]  cfg_div5;
    logic        tx_en5;
    logic        wr_valid5;
    logic [4:0]  wr_data5;
    logic        wr_ready5;
    logic        tx5;
    logic        busy5;
    logic [2:0]  count5;
    logic        empty5;
    logic        full5;

    tcore_uart_tx #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_div_i    (cfg_div),
        .cfg_parity_i (cfg_par),
        .cfg_stop2_i  (cfg_stop2),
        .tx_en_i      (tx_en),
        .wr_valid_i   (wr_valid),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .tx_o         (tx),
        .busy_o       (busy),
        .fifo_count_o (count),
        .fifo_empty_o (empty),
        .fifo_full_o  (full)
    );

    tcore_uart_tx #(.DATA_W(5), .FIFO_DEPTH(4), .DIV_W(8)) dut5 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_div_i    (cfg_div5),
        .cfg_parity_i (2'b00),
        .cfg_stop2_i  (1'b0),
        .tx_en_i      (tx_en5),
        .wr_valid_i   (wr_valid5),
        .wr_data_i    (wr_data5),
        .wr_ready_o   (wr_ready5),
        .tx_o         (tx5),
        .busy_o       (busy5),
        .fifo_count_o (count5),
        .fifo_empty_o (empty5),
        .fifo_full_o  (full5)
    );

    typedef struct {
        logic [7:0]  data;
        bit          has_par;
        bit          par_bit;
        bit          stop2;
        int unsigned div;
        bit          gap0;
    } frame_t;

    frame_t      sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          in_frame = 1'b0;
    int unsigned idle_run = 0;

    function automatic frame_t mk(input logic [7:0] d, input bit hp, input bit pb,
                                  input bit s2, input int unsigned dv, input bit g);
        frame_t f;
        f.data = d; f.has_par = hp; f.par_bit = pb; f.stop2 = s2; f.div = dv; f.gap0 = g;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr8(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned budget, input string name);
        int unsigned n = 0;
        while ((sb.size() != 0 || in_frame || busy === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 1);
        @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        int unsigned n = 0;
        while (busy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 1);
    endtask

    // Monitor: each low level on an idle line is a start bit; every bit is checked for its full period.
    initial begin : monitor
        frame_t f;
        logic   exp_bits[$];
        bit     ok;
        bit     aborted;
        int     n;
        @(negedge clk);
        forever begin
            if (rst_n === 1'b1 && tx === 1'b0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    n = 0;
                    while (tx === 1'b0 && n < 2000) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    f = sb.pop_front();
                    in_frame = 1'b1;
                    if (f.gap0) chk($sformatf("gap_before_%02h", f.data), idle_run, 0);
                    exp_bits.delete();
                    exp_bits.push_back(1'b0);
                    for (int i = 0; i < 8; i++) exp_bits.push_back(f.data[i]);
                    if (f.has_par) exp_bits.push_back(f.par_bit);
                    exp_bits.push_back(1'b1);
                    if (f.stop2) exp_bits.push_back(1'b1);
                    aborted = 1'b0;
                    foreach (exp_bits[b]) begin
                        ok = 1'b1;
                        for (int unsigned c = 0; c <= f.div; c++) begin
                            if (rst_n !== 1'b1) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (tx !== exp_bits[b] || busy !== 1'b1) ok = 1'b0;
                            @(negedge clk);
                        end
                        if (aborted) break;
                        chk($sformatf("frame_%02h_bit%0d", f.data, b), 32'(ok), 1);
                    end
                    in_frame = 1'b0;
                    idle_run = 0;
                    if (!aborted && sb.size() == 0)
                        chk($sformatf("idle_after_%02h", f.data), {30'd0, busy, tx}, 32'h1);
                end
            end else begin
                idle_run++;
                @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [15:0] cap_tx;
        logic [15:0] cap_busy;
        int          bc;

        rst_n = 1'b0; cfg_div = 16'd3; cfg_par = 2'b00; cfg_stop2 = 1'b0;
        tx_en = 1'b0; wr_valid = 1'b1; wr_data = 8'hEE;
        cfg_div5 = 8'd1; tx_en5 = 1'b0; wr_valid5 = 1'b1; wr_data5 = 5'h15;

        // Reset held with writes requested
        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_ready", 32'(wr_ready), 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_ready5", 32'(wr_ready5), 0);
        chk("reset_flags5", {30'd0, empty5, full5}, 32'h2);
        rst_n = 1'b1; wr_valid = 1'b0; wr_valid5 = 1'b0;
        #1;
        chk("ready_after_release", 32'(wr_ready), 1);
        @(negedge clk);
        chk("count_after_release", 32'(count), 0);

        // DATA_W = 5, divisor 1: 0x0A then 0x1F, captured over 16 cycles each
        tx_en5 = 1'b1;
        wr_valid5 = 1'b1; wr_data5 = 5'h0A;
        @(negedge clk);
        wr_valid5 = 1'b0;
        chk("w5_count", 32'(count5), 1);
        for (int i = 0; i < 16; i++) begin
            cap_tx   = {cap_tx[14:0], tx5};
            cap_busy = {cap_busy[14:0], busy5};
            @(negedge clk);
        end
        chk("w5_tx_0a", 32'(cap_tx), 32'h8667);
        chk("w5_busy_0a", 32'(cap_busy), 32'h7FFE);
        wr_valid5 = 1'b1; wr_data5 = 5'h1F;
        @(negedge clk);
        wr_valid5 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cap_tx   = {cap_tx[14:0], tx5};
            cap_busy = {cap_busy[14:0], busy5};
            @(negedge clk);
        end
        chk("w5_tx_1f", 32'(cap_tx), 32'h9FFF);
        chk("w5_busy_1f", 32'(cap_busy), 32'h7FFE);
        chk("w5_empty", 32'(empty5), 1);

        // Basic frame, latency and busy length
        tx_en = 1'b1;
        sb.push_back(mk(8'hA5, 0, 0, 0, 3, 0));
        wr8(8'hA5);
        chk("lat_count", 32'(count), 1);
        chk("lat_tx_high", 32'(tx), 1);
        @(negedge clk);
        chk("lat_tx_low", 32'(tx), 0);
        bc = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
        end
        chk("busy_len", 32'(bc), 40);
        wait_idle(200, "drain_basic");

        // Parity modes, stop bits, reserved mode, divisor 0
        cfg_par = 2'b01; cfg_stop2 = 1'b1;
        sb.push_back(mk(8'h07, 1, 1, 1, 3, 0));
        wr8(8'h07);
        wait_idle(200, "drain_even");
        cfg_par = 2'b10; cfg_stop2 = 1'b0;
        sb.push_back(mk(8'h07, 1, 0, 0, 3, 0));
        wr8(8'h07);
        wait_idle(200, "drain_odd");
        cfg_par = 2'b11;
        sb.push_back(mk(8'h3B, 0, 0, 0, 3, 0));
        wr8(8'h3B);
        wait_idle(200, "drain_reserved");
        cfg_par = 2'b00; cfg_div = 16'd0;
        sb.push_back(mk(8'h81, 0, 0, 0, 0, 0));
        wr8(8'h81);
        wait_idle(200, "drain_div0");
        cfg_div = 16'd3;

        // Full FIFO: 17 writes with TX disabled, then drain back-to-back
        tx_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 15) chk("not_full_at15", 32'(full), 0);
            if (i == 16) begin
                chk("full_flag", 32'(full), 1);
                chk("full_ready", 32'(wr_ready), 0);
                chk("full_count", 32'(count), 16);
            end
            if (i < 16) sb.push_back(mk(8'(i), 0, 0, 0, 3, (i > 0)));
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("full_count_after_drop", 32'(count), 16);
        tx_en = 1'b1;
        wait_idle(1500, "drain_full");
        chk("drained_empty", 32'(empty), 1);
        chk("drained_count", 32'(count), 0);

        // Write coinciding with a pop in the last STOP cycle
        tx_en = 1'b0;
        sb.push_back(mk(8'h11, 0, 0, 0, 3, 0));
        sb.push_back(mk(8'h22, 0, 0, 0, 3, 1));
        wr8(8'h11);
        wr8(8'h22);
        tx_en = 1'b1;
        wait_busy("sim_start");
        repeat (39) @(negedge clk);
        chk("sim_count_pre", 32'(count), 1);
        sb.push_back(mk(8'h3C, 0, 0, 0, 3, 1));
        wr_valid = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("sim_count_post", 32'(count), 1);
        chk("sim_busy", 32'(busy), 1);
        wait_idle(400, "drain_sim");
        chk("sim_count_end", 32'(count), 0);

        // Divisor change during DATA affects only the next frame
        tx_en = 1'b0;
        sb.push_back(mk(8'h96, 0, 0, 0, 3, 0));
        sb.push_back(mk(8'h69, 0, 0, 0, 7, 1));
        wr8(8'h96);
        wr8(8'h69);
        tx_en = 1'b1;
        wait_busy("div_start");
        repeat (12) @(negedge clk);
        cfg_div = 16'd7;
        wait_idle(400, "drain_div");
        cfg_div = 16'd3;

        // tx_en dropped mid-frame
        sb.push_back(mk(8'h5A, 0, 0, 0, 3, 0));
        wr8(8'h5A);
        wait_busy("en_start");
        repeat (8) @(negedge clk);
        wr8(8'hC3);
        tx_en = 1'b0;
        wait_idle(200, "drain_en");
        repeat (20) @(negedge clk);
        chk("hold_count", 32'(count), 1);
        chk("hold_busy", 32'(busy), 0);
        chk("hold_tx", 32'(tx), 1);
        sb.push_back(mk(8'hC3, 0, 0, 0, 3, 0));
        tx_en = 1'b1;
        wait_idle(200, "drain_reen");

        // Reset mid-frame
        sb.push_back(mk(8'hF0, 0, 0, 0, 3, 0));
        wr8(8'hF0);
        wr8(8'h0F);
        wait_busy("rst_start");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", 32'(tx), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        sb.delete();
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("postrst_busy", 32'(busy), 0);
        chk("postrst_tx", 32'(tx), 1);
        chk("postrst_count", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcore_uart_tx.md
# tcore_uart_tx

Parametrised UART transmitter with an integrated TX FIFO, generalising the fixed 8-bit, 16x-oversampled UART settings of the TCORE core package. Data width, FIFO depth and divisor width are compile-time parameters. Baud divisor, parity mode and stop-bit count are run-time configuration inputs. The block sits behind the peripheral register interface and drives the serial `tx_o` pin directly.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, at least 2.
- `DIV_W`, 16: width of the baud divisor input.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `cfg_div_i` in DIV_W: bit period is `cfg_div_i + 1` clocks.
- `cfg_parity_i` in 2: parity mode.
  - 00 = none.
  - 01 = even.
  - 10 = odd.
  - 11 = none (reserved).
- `cfg_stop2_i` in 1: 0 = one stop bit, 1 = two stop bits.
- `tx_en_i` in 1: permits new frames to start.
- `wr_valid_i` in 1: write request.
- `wr_data_i` in DATA_W: write data.
- `wr_ready_o` out 1: FIFO can accept a write.
- `tx_o` out 1: serial line; idles high.
- `busy_o` out 1: a frame is in flight.
- `fifo_count_o` out $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- `fifo_empty_o` out 1: FIFO empty.
- `fifo_full_o` out 1: FIFO full.

## Operation
- **FIFO write**
  - A write is accepted when `wr_valid_i && wr_ready_o`.
  - `wr_ready_o = !fifo_full_o && rst_ni`.
  - Read and write pointers wrap modulo FIFO_DEPTH; the count is tracked separately.
- **FIFO pop**
  - Exactly one pop per frame, at frame start.
  - Write and pop in the same cycle: count unchanged, both pointers advance.
  - When full, `wr_ready_o` is 0 even in a pop cycle; the freed slot is visible next cycle.
- **FSM states**: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx_o` = 1.
  - If `tx_en_i && !fifo_empty_o`, the block pops the head entry and latches data, `cfg_div_i`, `cfg_parity_i` and `cfg_stop2_i`, then moves to START.
- **START**: `tx_o` = 0 for one bit period.
- **DATA**
  - DATA_W bit periods, LSB first, driven from a shift register.
  - A bit index counter runs 0..DATA_W-1.
- **PARITY**
  - Entered only if the latched parity mode is 01 or 10.
  - Even mode sends the XOR of the data bits; odd mode sends its inverse.
  - For parity mode 00 or 11, DATA goes directly to STOP.
- **STOP**
  - `tx_o` = 1 for 1 or 2 bit periods.
  - In the last cycle of STOP: if `tx_en_i && !fifo_empty_o`, the block pops, latches and goes straight to START (no idle gap); otherwise it goes to IDLE.
- **Baud counter**
  - Loaded with the latched divisor on every state/bit entry.
  - Decrements each clock; the bit ends when the counter reaches 0.
  - Divisor 0 gives a one-clock bit.
- **Configuration changes mid-frame**: ignored; they take effect at the next frame start.
- **`tx_en_i` deasserted mid-frame**: the current frame completes; no new frame starts.
- `busy_o` = 1 in every state except IDLE.

## Timing
- **Reset** (`rst_ni` low at a clock edge): on the next edge
  - `tx_o` = 1, `busy_o` = 0, `fifo_count_o` = 0;
  - `fifo_empty_o` = 1, `fifo_full_o` = 0;
  - FSM = IDLE, pointers = 0.
  - Reset mid-frame aborts the frame immediately: the line returns high and FIFO contents are discarded.
- **Write latency**
  - A write accepted at edge t updates the count and flags at t+1.
  - From IDLE with `tx_en_i` high, `tx_o` falls at t+2.
- **Frame length**: (1 + DATA_W + P + S) × (`cfg_div_i` + 1) clocks.
  - P = 1 if parity is enabled, else 0.
  - S = 1 or 2.
- **Back-to-back frames**: the next start bit follows the final stop bit with zero gap.
- `fifo_full_o` asserts the cycle after the DEPTH-th outstanding write. Writes while full are dropped because ready is 0.

## Test plan
- **Reset**: hold `rst_ni` = 0 for 3 cycles with `wr_valid_i` = 1 -> `tx_o` = 1, `busy_o` = 0, count 0, `wr_ready_o` = 0; after release, `wr_ready_o` = 1.
- **Basic frame**: DATA_W = 8, div = 3, no parity, 1 stop; write 0xA5 -> `tx_o` sequence 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 clocks; frame = 40 clocks; `busy_o` high exactly 40 clocks.
- **Parity and stop bits**:
  - Even parity, 2 stop, data 0x07 -> parity bit 1, stop high for 2 bit periods.
  - Odd parity, data 0x07 -> parity bit 0.
  - DATA_W = 5, data 0x1F -> 5 data bits only.
- **Full FIFO**: `tx_en_i` = 0; write 17 words 0..16 at DEPTH = 16 -> full asserts after the 16th, the 17th is dropped, count = 16; enable TX -> words 0..15 are sent back-to-back with no idle gap, then empty.
- **Simultaneous write and pop**: FIFO holds 1 entry; in the STOP last cycle, write 0x3C while a pop occurs -> count stays 1, next frame carries the old head, then 0x3C.
- **Mid-frame events**:
  - Change `cfg_div_i` from 3 to 7 during DATA -> the current frame keeps 4-clock bits, the next frame uses 8.
  - Drop `tx_en_i` mid-frame -> the frame completes, then IDLE.
  - Assert reset mid-frame -> `tx_o` = 1 on the next edge, count 0.
